// File: rtl/data_mem_responder_if.sv
// Initiator/responder bus for the wait-stated data memory.
// The master drives request signals; the slave returns data, stall and error flags.
interface data_mem_responder_if #(
   parameter int WORD_SIZE = 16
);
   logic [WORD_SIZE-1:0] DataAddr;
   logic [WORD_SIZE-1:0] DataOut;
   logic                 ReadData;
   logic                 WriteData;
   logic                 ErrClear;
   logic [WORD_SIZE-1:0] DataIn;
   logic                 DataWaitreq;
   logic                 ProtoErr;
   logic                 AddrErr;

   modport master (
      output DataAddr, DataOut, ReadData, WriteData, ErrClear,
      input  DataIn, DataWaitreq, ProtoErr, AddrErr
   );

   modport slave (
      input  DataAddr, DataOut, ReadData, WriteData, ErrClear,
      output DataIn, DataWaitreq, ProtoErr, AddrErr
   );
endinterface

// File: rtl/data_mem_responder.sv
// Wait-stated single-port data memory responder with sticky protocol and address error flags.
// Handshake: a request (ReadData|WriteData) is held stable while DataWaitreq is high; the access completes in the one cycle DataWaitreq is low (ACK).
module data_mem_responder #(
   parameter int WORD_SIZE   = 16,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  Clock,
   input  logic                  Reset,
   data_mem_responder_if.slave   bus,
   output logic [1:0]            dbg_state
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   localparam logic [WORD_SIZE:0] DEPTH_LIM = (WORD_SIZE + 1)'(DEPTH);
   localparam logic [3:0]         CNT_LOAD  = 4'(WAIT_CYCLES - 1);

   logic [1:0]           state;
   logic [3:0]           cnt;
   logic [AW-1:0]        lat_idx;
   logic [WORD_SIZE-1:0] lat_wdata;
   logic                 lat_write;
   logic                 lat_in_range;
   logic [WORD_SIZE-1:0] rd_reg;
   logic                 proto_err;
   logic                 addr_err;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   logic req;
   logic both_req;
   logic addr_in_range;
   logic proto_evt;
   logic addr_evt;
   logic commit;
   logic rd_load;

   always_comb begin
      req           = bus.ReadData | bus.WriteData;
      both_req      = bus.ReadData & bus.WriteData;
      // Range check uses the full address even though decoding uses only the low bits.
      addr_in_range = ({1'b0, bus.DataAddr} < DEPTH_LIM);
      proto_evt     = ((state == IDLE) && both_req) || ((state == WAIT) && !req);
      addr_evt      = (state == IDLE) && req && !addr_in_range;
      commit        = (state == ACK) && lat_write && lat_in_range;
      rd_load       = (state == WAIT) && req && (cnt == 4'd0) && !lat_write;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         lat_idx      <= '0;
         lat_wdata    <= '0;
         lat_write    <= 1'b0;
         lat_in_range <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  lat_idx      <= bus.DataAddr[AW-1:0];
                  lat_wdata    <= bus.DataOut;
                  lat_write    <= bus.WriteData;
                  lat_in_range <= addr_in_range;
                  cnt          <= CNT_LOAD;
                  state        <= WAIT;
               end
            end
            WAIT: begin
               // A dropped request abandons the access; nothing is committed.
               if (!req) begin
                  state <= IDLE;
               end else if (cnt == 4'd0) begin
                  state <= ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         rd_reg <= '0;
      end else if (rd_load) begin
         rd_reg <= lat_in_range ? mem[lat_idx] : '0;
      end
   end

   // New error events win over a same-cycle clear.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         proto_err <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         proto_err <= proto_evt | (proto_err & ~bus.ErrClear);
         addr_err  <= addr_evt  | (addr_err  & ~bus.ErrClear);
      end
   end

   always_ff @(posedge Clock) begin
      if (commit) begin
         mem[lat_idx] <= lat_wdata;
      end
   end

   always_comb begin
      case (state)
         IDLE:    bus.DataWaitreq = req;
         WAIT:    bus.DataWaitreq = 1'b1;
         default: bus.DataWaitreq = 1'b0;
      endcase
      bus.DataIn   = ((state == ACK) && !lat_write) ? rd_reg : '0;
      bus.ProtoErr = proto_err;
      bus.AddrErr  = addr_err;
      dbg_state    = state;
   end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WORD_SIZE, default 16, data and address width in bits.
REQ-002 Parameter DEPTH, default 256, number of WORD_SIZE-bit words stored; power of two, at most 2^WORD_SIZE.
REQ-003 Parameter WAIT_CYCLES, default 2, wait-state count per access; legal range 1..15.
REQ-004 Clock  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 DataAddr  input  WORD_SIZE  word address from the initiator.
REQ-007 DataOut  input  WORD_SIZE  write data from the initiator.
REQ-008 ReadData  input  1  read request strobe.
REQ-009 WriteData  input  1  write request strobe.
REQ-010 ErrClear  input  1  synchronous clear of the error flags.
REQ-011 DataIn  output  WORD_SIZE  read data returned to the initiator.
REQ-012 DataWaitreq  output  1  stall request; the initiator holds all request signals stable while it is high.
REQ-013 ProtoErr  output  1  sticky protocol-violation flag.
REQ-014 AddrErr  output  1  sticky out-of-range-address flag.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT, ACK.
REQ-016 A request SHALL be defined as ReadData OR WriteData being high.
REQ-017 In IDLE, DataWaitreq SHALL equal the request signal combinationally, so the initiator stalls in the same cycle it presents the request.
REQ-018 IDLE with a request SHALL latch DataAddr, DataOut and the access type, load the counter with WAIT_CYCLES-1, and move to WAIT.
REQ-019 In WAIT, DataWaitreq SHALL be 1 and the counter SHALL decrement each cycle; with the counter at 0, the FSM SHALL move to ACK.
REQ-020 On a read, the WAIT-to-ACK edge SHALL register mem[latched address] into an internal read register.
REQ-021 In ACK, DataWaitreq SHALL be 0; for a read, DataIn SHALL equal the read register; the FSM SHALL return to IDLE on the next edge.
REQ-022 For a write, mem[latched address] SHALL take the latched DataOut on the ACK-to-IDLE edge.
REQ-023 DataIn SHALL be 0 in every cycle other than an ACK cycle of a read.
REQ-024 DataWaitreq SHALL be high for exactly WAIT_CYCLES+1 consecutive cycles per access, then low for one ACK cycle.
REQ-025 A new request presented in the cycle after ACK SHALL start a new access from IDLE, with no extra gap cycle.
REQ-026 If ReadData and WriteData are both high in IDLE, the access SHALL execute as a write and ProtoErr SHALL set.
REQ-027 If the request drops while in WAIT, the FSM SHALL abort to IDLE without any memory write and ProtoErr SHALL set.
REQ-028 Address changes during WAIT SHALL be ignored, because the latched address is used.
REQ-029 If the latched address is DEPTH or greater:
- AddrErr SHALL set at latch time.
- A read SHALL return 0.
- A write SHALL be discarded.
- The handshake timing SHALL be unchanged.
REQ-030 ErrClear SHALL clear both flags on the next edge; a new error event in the same cycle SHALL take priority, leaving the flag set.
REQ-031 Address decoding SHALL use the low log2(DEPTH) bits, with the range check applied on the full address.

Reset
REQ-032 Reset high SHALL immediately force:
- state to IDLE
- counter to 0
- read register to 0
- ProtoErr and AddrErr to 0
REQ-033 During reset, DataIn SHALL be 0 and DataWaitreq SHALL follow REQ-017 from IDLE.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 A write aborted by reset before its ACK-to-IDLE edge SHALL NOT be committed.
REQ-036 After reset deasserts, the first request SHALL be handled normally from IDLE.

Verification
REQ-037 Write then read, WAIT_CYCLES=2:
- Stimulus: write 0xBEEF to address 0x0010, then read 0x0010.
- Response: DataWaitreq high for 3 cycles then low for 1 in each access; DataIn=0xBEEF in the read's ACK cycle; DataIn=0 in all other cycles.
REQ-038 Back-to-back reads:
- Stimulus: read 0x0001, then read 0x0002 in the cycle after ACK.
- Response: the second access's DataWaitreq rises in that same cycle; exactly 8 cycles total for both accesses.
REQ-039 Out-of-range address, DEPTH=256:
- Stimulus: write 0x1234 to address 0x0100, then read 0x0000.
- Response: AddrErr=1; mem[0x00] is unchanged; the read returns the prior value.
REQ-040 Protocol errors and clear:
- Stimulus 1: ReadData=WriteData=1 with DataOut=0x00AA at 0x0005. Response: write executes, ProtoErr=1.
- Stimulus 2: pulse ErrClear. Response: ProtoErr=0.
- Stimulus 3: drop WriteData mid-WAIT. Response: FSM returns to IDLE, no write occurs, ProtoErr=1.
REQ-041 Reset mid-write:
- Stimulus: write 0x5555 to 0x0007 (prior value 0x1111); assert Reset in the second WAIT cycle.
- Response: DataIn=0 immediately; both flags 0; a later read of 0x0007 returns 0x1111.
